// File: rtl/clock_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_divider_pkg
//  Description : Shared types, helpers and elaboration checks for the
//                clock_divider_bank slice.
//                - cfg_field_t / div_cfg_t : width-independent config carrier
//                  (32-bit fields; any DIV_WIDTH up to 32 zero-extends in).
//                - cfg_valid()             : legality of a {divisor, high} pair.
//                - CDB_ELAB_CHECK          : generate-time parameter check.
//  Revision    : 1.0 - initial release
// ============================================================================

// Expands to a labelled generate-if that raises an elaboration error when
// COND is false. Use at module scope only.
`define CDB_ELAB_CHECK(LABEL, COND, MSG) \
  if (!(COND)) begin : LABEL \
    $error(MSG); \
  end

package clock_divider_pkg;

  // Config fields are carried at the widest supported DIV_WIDTH so the
  // helper below works for every instance without re-parameterisation.
  localparam int unsigned CFG_FIELD_W = 32;

  typedef logic [CFG_FIELD_W-1:0] cfg_field_t;

  typedef struct packed {
    cfg_field_t div;
    cfg_field_t high;
  } div_cfg_t;

  // A period must be at least 2 cycles and the output must spend at least
  // one cycle high and one cycle low in it.
  function automatic logic cfg_valid(input cfg_field_t div, input cfg_field_t high);
    return (div >= 32'd2) && (high >= 32'd1) && (high < div);
  endfunction

endpackage

`default_nettype wire

// File: rtl/clock_divider_channel.sv
`default_nettype none
// ============================================================================
//  Module      : clock_divider_channel
//  Description : One programmable divider channel. Holds the period counter,
//                the active {div, high} pair, a one-entry pending slot and the
//                registered output level / rising-edge pulse.
//  Ports       : clk_i, reset_i   - clock, synchronous active-high reset
//                enable_i          - run enable (level)
//                sync_i            - force a period start next cycle
//                load_i            - write load_div_i/load_high_i to pending
//                pending_o         - pending slot occupied
//                clk_o             - divided clock level (registered)
//                clk_en_o          - one-cycle pulse on first high cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_divider_channel
  import clock_divider_pkg::*;
#(
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic                 sync_i,
  input  logic                 load_i,
  input  logic [DIV_WIDTH-1:0] load_div_i,
  input  logic [DIV_WIDTH-1:0] load_high_i,
  output logic                 pending_o,
  output logic                 clk_o,
  output logic                 clk_en_o
);

  localparam logic [DIV_WIDTH-1:0] c_rst_div  = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] c_rst_high = DIV_WIDTH'(DEFAULT_DIV / 2);
  localparam logic [DIV_WIDTH-1:0] c_one      = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] div_q,   div_d;
  logic [DIV_WIDTH-1:0] high_q,  high_d;
  logic [DIV_WIDTH-1:0] pdiv_q,  pdiv_d;
  logic [DIV_WIDTH-1:0] phigh_q, phigh_d;
  logic                 pend_q,  pend_d;
  logic [DIV_WIDTH-1:0] cnt_q,   cnt_d;
  logic                 clk_q,   clk_d;
  logic                 en_q,    en_d;

  always_comb begin
    div_d   = div_q;
    high_d  = high_q;
    pdiv_d  = pdiv_q;
    phigh_d = phigh_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    clk_d   = 1'b0;
    en_d    = 1'b0;

    if (!enable_i) begin
      // Parked at the last count so re-enable lands on a fresh period start.
      cnt_d = div_q - c_one;
    end else begin
      // Sync and a natural wrap both just start a new period, so their
      // coincidence still yields exactly one Counter=0 cycle.
      if (sync_i || (cnt_q == div_q - c_one)) begin
        cnt_d = '0;
        if (pend_q) begin
          div_d  = pdiv_q;
          high_d = phigh_q;
          pend_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + c_one;
      end
      // Outputs reflect the counter value that will be held next cycle,
      // using the config in force for that cycle.
      clk_d = (cnt_d < high_d);
      en_d  = (cnt_d == '0);
    end

    // The top only loads an empty slot, so this never races the boundary
    // clear above; a load on a boundary cycle waits for the next one.
    if (load_i) begin
      pdiv_d  = load_div_i;
      phigh_d = load_high_i;
      pend_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_q   <= c_rst_div;
      high_q  <= c_rst_high;
      pdiv_q  <= c_rst_div;
      phigh_q <= c_rst_high;
      pend_q  <= 1'b0;
      cnt_q   <= c_rst_div - c_one;
      clk_q   <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      high_q  <= high_d;
      pdiv_q  <= pdiv_d;
      phigh_q <= phigh_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      clk_q   <= clk_d;
      en_q    <= en_d;
    end
  end

  assign pending_o = pend_q;
  assign clk_o     = clk_q;
  assign clk_en_o  = en_q;

endmodule

`default_nettype wire

// File: rtl/clock_divider_bank.sv
`default_nettype none
// ============================================================================
//  Module      : clock_divider_bank
//  Description : Multi-channel runtime-programmable integer clock divider.
//                Decodes the config handshake, reports rejected requests and
//                fans out to CHANNELS independent divider channels.
//  Ports       : clk_i, reset_i          - clock, synchronous active-high reset
//                channel_enable_i        - per-channel run enable
//                sync_i                  - realign all enabled channels
//                cfg_valid_i/cfg_ready_o - config handshake
//                cfg_channel_i           - target channel
//                cfg_divisor_i           - period N (Clk cycles)
//                cfg_high_i              - high time H (Clk cycles)
//                cfg_error_o             - one-cycle pulse, request rejected
//                clk_output_o            - divided clock levels
//                clk_enable_output_o     - per-period enable pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_divider_bank
  import clock_divider_pkg::*;
#(
  parameter  int CHANNELS    = 4,
  parameter  int DIV_WIDTH   = 16,
  parameter  int DEFAULT_DIV = 2,
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [CHANNELS-1:0]  channel_enable_i,
  input  logic                 sync_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [CH_W-1:0]      cfg_channel_i,
  input  logic [DIV_WIDTH-1:0] cfg_divisor_i,
  input  logic [DIV_WIDTH-1:0] cfg_high_i,
  output logic                 cfg_error_o,
  output logic [CHANNELS-1:0]  clk_output_o,
  output logic [CHANNELS-1:0]  clk_enable_output_o
);

  `CDB_ELAB_CHECK(g_chk_channels, (CHANNELS >= 1) && (CHANNELS <= 32),
                  "clock_divider_bank: CHANNELS must be in 1..32")
  `CDB_ELAB_CHECK(g_chk_width, (DIV_WIDTH >= 2) && (DIV_WIDTH <= 32),
                  "clock_divider_bank: DIV_WIDTH must be in 2..32")
  `CDB_ELAB_CHECK(g_chk_div_min, DEFAULT_DIV >= 2,
                  "clock_divider_bank: DEFAULT_DIV must be >= 2")
  `CDB_ELAB_CHECK(g_chk_div_max, 64'(DEFAULT_DIV) <= ((64'd1 << DIV_WIDTH) - 64'd1),
                  "clock_divider_bank: DEFAULT_DIV exceeds 2^DIV_WIDTH-1")

  // Every encodable channel index gets a slot; indices beyond CHANNELS read
  // as "free" so an out-of-range request is consumed and then rejected.
  localparam int c_slots = 2 ** CH_W;

  logic [CHANNELS-1:0] pending;
  logic [c_slots-1:0]  pend_ext;
  div_cfg_t            req;
  logic                req_accept;
  logic                req_in_range;
  logic                req_good;
  logic                cfg_error_q, cfg_error_d;

  assign pend_ext    = c_slots'(pending);
  assign cfg_ready_o = ~pend_ext[cfg_channel_i];

  assign req.div      = cfg_field_t'(cfg_divisor_i);
  assign req.high     = cfg_field_t'(cfg_high_i);
  assign req_accept   = cfg_valid_i & cfg_ready_o;
  assign req_in_range = (cfg_field_t'(cfg_channel_i) < cfg_field_t'(CHANNELS));
  assign req_good     = req_accept & req_in_range & cfg_valid(req.div, req.high);
  assign cfg_error_d  = req_accept & ~req_good;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cfg_error_q <= 1'b0;
    end else begin
      cfg_error_q <= cfg_error_d;
    end
  end

  assign cfg_error_o = cfg_error_q;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic load;

    assign load = req_good & (cfg_channel_i == CH_W'(gi));

    clock_divider_channel #(
      .DIV_WIDTH   (DIV_WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .enable_i    (channel_enable_i[gi]),
      .sync_i      (sync_i),
      .load_i      (load),
      .load_div_i  (cfg_divisor_i),
      .load_high_i (cfg_high_i),
      .pending_o   (pending[gi]),
      .clk_o       (clk_output_o[gi]),
      .clk_en_o    (clk_enable_output_o[gi])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_clock_divider_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clock_divider_bank
//  Description : Self-checking bench for clock_divider_bank. A period-start
//                timeline model predicts every output each cycle; directed
//                literal expectations pin the model's behaviour.
//                Five channels are used so that an out-of-range channel
//                index is encodable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_divider_bank;

  localparam int CHANNELS    = 5;
  localparam int DIV_WIDTH   = 16;
  localparam int DEFAULT_DIV = 2;
  localparam int CH_W        = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [CHANNELS-1:0]  ch_en;
  logic                 sync;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CH_W-1:0]      cfg_channel;
  logic [DIV_WIDTH-1:0] cfg_div;
  logic [DIV_WIDTH-1:0] cfg_high;
  logic                 cfg_error;
  logic [CHANNELS-1:0]  clk_out;
  logic [CHANNELS-1:0]  clk_en;

  clock_divider_bank #(
    .CHANNELS    (CHANNELS),
    .DIV_WIDTH   (DIV_WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clk_i               (clk),
    .reset_i             (reset),
    .channel_enable_i    (ch_en),
    .sync_i              (sync),
    .cfg_valid_i         (cfg_valid),
    .cfg_ready_o         (cfg_ready),
    .cfg_channel_i       (cfg_channel),
    .cfg_divisor_i       (cfg_div),
    .cfg_high_i          (cfg_high),
    .cfg_error_o         (cfg_error),
    .clk_output_o        (clk_out),
    .clk_enable_output_o (clk_en)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: each channel is a timeline of period starts ----
  int  cyc_n = 0;
  bit  live  = 1'b0;
  int  m_div   [CHANNELS];
  int  m_high  [CHANNELS];
  int  m_pdiv  [CHANNELS];
  int  m_phigh [CHANNELS];
  int  m_start [CHANNELS];
  bit  m_pend  [CHANNELS];
  bit  m_idle  [CHANNELS];
  bit  exp_clk [CHANNELS];
  bit  exp_en  [CHANNELS];
  bit  exp_err;

  task automatic model_step();
    int ch;
    int ph;
    bit acc;
    bit good;
    cyc_n++;
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        m_div[c]   = DEFAULT_DIV;
        m_high[c]  = DEFAULT_DIV / 2;
        m_pend[c]  = 1'b0;
        m_idle[c]  = 1'b1;
        m_start[c] = 0;
        exp_clk[c] = 1'b0;
        exp_en[c]  = 1'b0;
      end
      exp_err = 1'b0;
      return;
    end
    ch   = int'(cfg_channel);
    acc  = 1'b0;
    good = 1'b0;
    if (cfg_valid) begin
      if (ch >= CHANNELS) acc = 1'b1;
      else                acc = !m_pend[ch];
    end
    if (acc && (ch < CHANNELS) && (cfg_div >= 2) && (cfg_high >= 1) && (cfg_high < cfg_div))
      good = 1'b1;
    for (int c = 0; c < CHANNELS; c++) begin
      if (!ch_en[c]) begin
        m_idle[c]  = 1'b1;
        exp_clk[c] = 1'b0;
        exp_en[c]  = 1'b0;
      end else begin
        if (m_idle[c] || sync || ((cyc_n - m_start[c]) == m_div[c])) begin
          m_start[c] = cyc_n;
          m_idle[c]  = 1'b0;
          if (m_pend[c]) begin
            m_div[c]  = m_pdiv[c];
            m_high[c] = m_phigh[c];
            m_pend[c] = 1'b0;
          end
        end
        ph         = cyc_n - m_start[c];
        exp_clk[c] = (ph < m_high[c]);
        exp_en[c]  = (ph == 0);
      end
    end
    if (good) begin
      m_pend[ch]  = 1'b1;
      m_pdiv[ch]  = int'(cfg_div);
      m_phigh[ch] = int'(cfg_high);
    end
    exp_err = acc && !good;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    live = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- compare process ---------------------------------------
  always @(negedge clk) begin
    if (live) begin
      for (int c = 0; c < CHANNELS; c++) begin
        check($sformatf("model clk_out[%0d]", c), 32'(clk_out[c]), 32'(exp_clk[c]));
        check($sformatf("model clk_en[%0d]", c), 32'(clk_en[c]), 32'(exp_en[c]));
      end
      check("model cfg_error", 32'(cfg_error), 32'(exp_err));
    end
  end

  task automatic send_cfg(input int ch, input int n, input int h);
    cfg_channel = CH_W'(ch);
    cfg_div     = DIV_WIDTH'(n);
    cfg_high    = DIV_WIDTH'(h);
    cfg_valid   = 1'b1;
    tick();
    cfg_valid   = 1'b0;
  endtask

  // ---------------- directed stimulus -------------------------------------
  initial begin : stim
    logic [9:0] seq_clk;
    logic [9:0] seq_en;
    logic [3:0] seq4;
    int         coin_at;

    reset       = 1'b1;
    ch_en       = '1;
    sync        = 1'b0;
    cfg_valid   = 1'b0;
    cfg_channel = '0;
    cfg_div     = '0;
    cfg_high    = '0;
    seq_clk     = '0;
    seq_en      = '0;
    seq4        = '0;
    coin_at     = -1;

    repeat (3) tick();
    check("reset clk_out", 32'(clk_out), 32'h0);
    check("reset clk_en", 32'(clk_en), 32'h0);
    check("reset cfg_ready", 32'(cfg_ready), 32'h1);

    // Default divide-by-2: first pulse one cycle after reset drops.
    reset = 1'b0;
    tick();
    check("first cycle clk_out", 32'(clk_out), 32'h1F);
    check("first cycle clk_en", 32'(clk_en), 32'h1F);
    tick();
    check("second cycle clk_out", 32'(clk_out), 32'h00);
    check("second cycle clk_en", 32'(clk_en), 32'h00);

    // ch1 N=5 H=2 accepted on a boundary cycle: current period finishes first.
    send_cfg(1, 5, 2);
    seq_clk = {seq_clk[8:0], clk_out[1]};
    seq_en  = {seq_en[8:0], clk_en[1]};
    cfg_channel = 3'd1;
    #1 check("ready ch1 while pending", 32'(cfg_ready), 32'h0);
    cfg_channel = 3'd2;
    #1 check("ready ch2 while ch1 pending", 32'(cfg_ready), 32'h1);
    // A second request to ch1 while its slot is full must not transfer.
    send_cfg(1, 3, 1);
    seq_clk = {seq_clk[8:0], clk_out[1]};
    seq_en  = {seq_en[8:0], clk_en[1]};
    for (int i = 0; i < 8; i++) begin
      tick();
      seq_clk = {seq_clk[8:0], clk_out[1]};
      seq_en  = {seq_en[8:0], clk_en[1]};
    end
    check("ch1 reprogram clk pattern", 32'(seq_clk), 32'(10'b1011000110));
    check("ch1 reprogram en pattern", 32'(seq_en), 32'(10'b1010000100));

    // Rejected requests: N=1, H=0, H=N, out-of-range channel.
    send_cfg(2, 1, 1);
    check("err N=1", 32'(cfg_error), 32'h1);
    send_cfg(2, 4, 0);
    check("err H=0", 32'(cfg_error), 32'h1);
    send_cfg(2, 4, 4);
    check("err H=N", 32'(cfg_error), 32'h1);
    send_cfg(5, 4, 2);
    check("err channel=5", 32'(cfg_error), 32'h1);
    cfg_channel = 3'd2;
    #1 check("ready ch2 after rejects", 32'(cfg_ready), 32'h1);
    tick();
    check("err cleared", 32'(cfg_error), 32'h0);

    // Edge-legal config H=N-1.
    send_cfg(3, 3, 2);
    check("no err H=N-1", 32'(cfg_error), 32'h0);

    // ch0 N=4, ch2 N=6, then Sync at an arbitrary phase.
    send_cfg(0, 4, 2);
    send_cfg(2, 6, 3);
    repeat (11) tick();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("sync all pulse", 32'(clk_en), 32'h1F);
    for (int i = 1; i <= 12; i++) begin
      tick();
      if ((coin_at < 0) && clk_en[0] && clk_en[2]) coin_at = i;
    end
    check("ch0/ch2 coincide after", 32'(coin_at), 32'd12);

    // Disable ch3, Sync while disabled, then re-enable.
    ch_en[3] = 1'b0;
    repeat (3) tick();
    check("ch3 disabled outputs", 32'({clk_out[3], clk_en[3]}), 32'h0);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("ch3 ignores sync", 32'({clk_out[3], clk_en[3]}), 32'h0);
    ch_en[3] = 1'b1;
    tick();
    check("ch3 reenable", 32'({clk_out[3], clk_en[3]}), 32'h3);
    tick();
    check("ch3 second cycle", 32'({clk_out[3], clk_en[3]}), 32'h2);

    // Reset mid-period with a pending config on ch1.
    send_cfg(1, 7, 3);
    cfg_channel = 3'd1;
    #1 check("ch1 pending before reset", 32'(cfg_ready), 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset mid clk_out", 32'(clk_out), 32'h0);
    check("reset mid clk_en", 32'(clk_en), 32'h0);
    check("reset clears pending", 32'(cfg_ready), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      seq4 = {seq4[2:0], clk_out[1]};
    end
    check("ch1 back to default period", 32'(seq4), 32'(4'b1010));

    repeat (4) tick();
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
